// File: rtl/apb_resp_pkg.sv
// Shared definitions for the APB word-memory responder.
//
// Contents: default bus and memory dimensions, the wait-counter width and
// the FSM state type. If APB_RESP_WAIT_EN is defined, the WAIT state exists.
// Without it, every transfer is zero-wait and WAIT is left out of the type.

package apb_resp_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 256;
   localparam int CNT_W      = 4;

`ifdef APB_RESP_WAIT_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/apb_resp_store.sv
// Word storage behind the APB responder.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset; reset clears every word
//   we          write enable; a write happens on the rising edge
//   waddr/wdata write word index and data
//   raddr       read word index
//   rdata       combinational read data (mem[raddr])

module apb_resp_store #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_responder.sv
// APB responder for a DEPTH x DATA_W word memory. Wait states are optional.
//
// Build option: APB_RESP_WAIT_EN. When it is defined, the responder inserts
// WAIT_CYCLES wait states per transfer (0..15). When it is undefined,
// WAIT_CYCLES is ignored and every transfer completes in its first access
// cycle.
//
// Ports:
//   clk      single clock, rising edge
//   Rst      asynchronous active-low reset
//   PAddr    word address; values >= DEPTH give an error response
//   PWData   write data
//   PWrite   1 = write, 0 = read
//   PSel     responder select
//   PEnable  access phase marker
//   PRData   registered read data; it is loaded on entry to READY
//   PReady   high in READY; the transfer completes at the edge with PSel&PEnable
//   PSlvErr  error response; it is valid only while PReady is high
//
// state | meaning
// IDLE  | waiting for a setup cycle (PSel=1, PEnable=0)
// WAIT  | counting wait states over access cycles (wait-state build only)
// READY | PReady high; completes on PSel&PEnable, aborts on PSel=0

module apb_responder
   import apb_resp_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] PAddr,
   input  logic [DATA_W-1:0] PWData,
   input  logic              PWrite,
   input  logic              PSel,
   input  logic              PEnable,
   output logic [DATA_W-1:0] PRData,
   output logic              PReady,
   output logic              PSlvErr
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                write_q, err_q;
   logic                setup, addr_err, mem_we, load_rd;
   logic [IDX_W-1:0]    rd_idx;
   logic                rd_write, rd_err;
   logic [DATA_W-1:0]   mem_rdata;

`ifdef APB_RESP_WAIT_EN
   logic [CNT_W-1:0]    cnt, cnt_nxt;
`else
   localparam int       unused_wait_cycles = WAIT_CYCLES;
`endif

   assign setup    = PSel & ~PEnable;
   assign addr_err = {1'b0, PAddr} >= DEPTH_LIM;

   // In a zero-wait transfer, READY is entered from IDLE. The transfer
   // attributes are therefore taken from the bus while they are latched.
   assign rd_idx   = (state == IDLE) ? PAddr[IDX_W-1:0] : idx_q;
   assign rd_write = (state == IDLE) ? PWrite : write_q;
   assign rd_err   = (state == IDLE) ? addr_err : err_q;

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
`ifdef APB_RESP_WAIT_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (setup) begin
`ifdef APB_RESP_WAIT_EN
               cnt_nxt   = CNT_W'(WAIT_CYCLES);
               state_nxt = (WAIT_CYCLES == 0) ? READY : WAIT;
`else
               state_nxt = READY;
`endif
            end
         end
`ifdef APB_RESP_WAIT_EN
         WAIT: begin
            if (!PSel) begin
               state_nxt = IDLE;
            end else if (PEnable) begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == CNT_W'(1)) state_nxt = READY;
            end
         end
`endif
         READY: begin
            if (!PSel) begin
               state_nxt = IDLE;
            end else if (PEnable) begin
               state_nxt = IDLE;
               mem_we    = write_q & ~err_q;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load_rd = (state_nxt == READY) && (state != READY);

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state   <= IDLE;
         idx_q   <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         PRData  <= '0;
`ifdef APB_RESP_WAIT_EN
         cnt     <= '0;
`endif
      end else begin
         state <= state_nxt;
`ifdef APB_RESP_WAIT_EN
         cnt   <= cnt_nxt;
`endif
         if (state == IDLE && setup) begin
            idx_q   <= PAddr[IDX_W-1:0];
            wdata_q <= PWData;
            write_q <= PWrite;
            err_q   <= addr_err;
         end
         // An errored transfer always shows zero. A write leaves the last read value.
         if (load_rd && (rd_err || !rd_write))
            PRData <= rd_err ? '0 : mem_rdata;
      end
   end

   assign PReady  = (state == READY);
   assign PSlvErr = (state == READY) & err_q;

   apb_resp_store #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_store (
      .clk   (clk),
      .rst_n (Rst),
      .we    (mem_we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (rd_idx),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_apb_responder.sv
module tb_apb_responder;

   localparam int WC = 2;
`ifdef APB_RESP_WAIT_EN
   localparam int LAT = WC + 1;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        Rst = 1'b0;
   logic [15:0] PAddr = '0;
   logic [31:0] PWData = '0;
   logic        PWrite = 1'b0;
   logic        PSel = 1'b0;
   logic        PEnable = 1'b0;
   logic [31:0] PRData;
   logic        PReady;
   logic        PSlvErr;

   apb_responder #(
      .ADDR_W      (16),
      .DATA_W      (32),
      .DEPTH       (256),
      .WAIT_CYCLES (WC)
   ) dut (
      .clk     (clk),
      .Rst     (Rst),
      .PAddr   (PAddr),
      .PWData  (PWData),
      .PWrite  (PWrite),
      .PSel    (PSel),
      .PEnable (PEnable),
      .PRData  (PRData),
      .PReady  (PReady),
      .PSlvErr (PSlvErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_read;
      logic [31:0] rdata;
      logic        err;
      logic        b2b;
      int          id;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc = 0;
   int last_done = 0;

   function automatic void chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (xfer %0d): got %h, want %h", nm, id, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: count access cycles since setup; check each completed transfer
   always @(negedge clk) begin
      exp_t e;
      if (Rst) begin
         if (PSel && !PEnable) acc = 0;
         else if (PSel && PEnable) acc = acc + 1;
         if (PSel && PEnable && PReady) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got PReady=1 at cycle %0d, want no completion", cyc);
            end else begin
               e = q.pop_front();
               chk("latency", e.id, 32'(acc), 32'(LAT));
               chk("pslverr", e.id, {31'b0, PSlvErr}, {31'b0, e.err});
               if (e.is_read) chk("prdata", e.id, PRData, e.rdata);
               if (e.b2b) chk("b2b_gap", e.id, 32'(cyc - last_done), 32'(LAT + 1));
               last_done = cyc;
            end
         end
      end
   end

   task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic exp_err, input logic b2b,
                       input int id);
      exp_t e;
      logic rdy, done;
      e.is_read = !wr;
      e.rdata   = exp_rd;
      e.err     = exp_err;
      e.b2b     = b2b;
      e.id      = id;
      q.push_back(e);
      PSel = 1'b1; PEnable = 1'b0; PWrite = wr; PAddr = addr; PWData = data;
      @(posedge clk); #1;
      // scramble the address and data bus in the access phase; the latched values must be used
      PEnable = 1'b1; PAddr = addr ^ 16'h005A; PWData = ~data;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         rdy = PReady;
         @(posedge clk); #1;
         done = rdy;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout (xfer %0d): got no PReady in 40 cycles, want PReady", id);
      end
   endtask

   task automatic idle(input int n);
      PSel = 1'b0; PEnable = 1'b0; PWrite = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready", 0, {31'b0, PReady}, 32'd0);
      chk("rst_pslverr", 0, {31'b0, PSlvErr}, 32'd0);
      chk("rst_prdata", 0, PRData, 32'd0);
      Rst = 1'b1;
      @(posedge clk); #1;

      // basic write/read
      xfer(1'b1, 16'h0050, 32'h0000_0050, 32'h0, 1'b0, 1'b0, 1);
      xfer(1'b0, 16'h0050, 32'h0, 32'h0000_0050, 1'b0, 1'b1, 2);
      idle(2);

      // out-of-range accesses
      xfer(1'b1, 16'h0100, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 3);
      idle(1);
      xfer(1'b0, 16'h0050, 32'h0, 32'h0000_0050, 1'b0, 1'b0, 4);
      xfer(1'b0, 16'h0100, 32'h0, 32'h0, 1'b1, 1'b1, 5);
      xfer(1'b0, 16'h00FF, 32'h0, 32'h0, 1'b0, 1'b1, 6);
      xfer(1'b0, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b1, 7);
      idle(1);

      // abort by dropping PSel mid-transfer
      PSel = 1'b1; PEnable = 1'b0; PWrite = 1'b1; PAddr = 16'h0010; PWData = 32'hA5A5_A5A5;
      @(posedge clk); #1;
`ifdef APB_RESP_WAIT_EN
      PEnable = 1'b1;
      @(posedge clk); #1;
`endif
      PSel = 1'b0; PEnable = 1'b0;
      @(posedge clk); #1;
      chk("abort_pready", 8, {31'b0, PReady}, 32'd0);
      chk("abort_pslverr", 8, {31'b0, PSlvErr}, 32'd0);
      xfer(1'b0, 16'h0010, 32'h0, 32'h0, 1'b0, 1'b0, 9);
      idle(1);

      // back-to-back transfers
      xfer(1'b1, 16'h0001, 32'h1, 32'h0, 1'b0, 1'b0, 10);
      xfer(1'b1, 16'h0002, 32'h2, 32'h0, 1'b0, 1'b1, 11);
      xfer(1'b0, 16'h0001, 32'h0, 32'h1, 1'b0, 1'b1, 12);
      xfer(1'b0, 16'h0002, 32'h0, 32'h2, 1'b0, 1'b1, 13);
      idle(1);

      // PEnable in IDLE with no setup is ignored
      PSel = 1'b1; PEnable = 1'b1; PWrite = 1'b1; PAddr = 16'h0003; PWData = 32'h33;
      repeat (3) @(posedge clk);
      #1;
      chk("noset_pready", 14, {31'b0, PReady}, 32'd0);
      idle(1);
      xfer(1'b0, 16'h0003, 32'h0, 32'h0, 1'b0, 1'b0, 15);
      xfer(1'b0, 16'h0002, 32'h0, 32'h2, 1'b0, 1'b1, 16);

      // reset during a write
      PSel = 1'b1; PEnable = 1'b0; PWrite = 1'b1; PAddr = 16'h0020; PWData = 32'h1234_5678;
      @(posedge clk); #1;
`ifdef APB_RESP_WAIT_EN
      PEnable = 1'b1;
      @(posedge clk); #1;
`endif
      Rst = 1'b0;
      #1;
      chk("rstmid_pready", 17, {31'b0, PReady}, 32'd0);
      chk("rstmid_pslverr", 17, {31'b0, PSlvErr}, 32'd0);
      chk("rstmid_prdata", 17, PRData, 32'd0);
      PSel = 1'b0; PEnable = 1'b0;
      @(posedge clk); #1;
      Rst = 1'b1;
      @(posedge clk); #1;
      xfer(1'b0, 16'h0020, 32'h0, 32'h0, 1'b0, 1'b0, 18);
      xfer(1'b0, 16'h0050, 32'h0, 32'h0, 1'b0, 1'b1, 19);
      xfer(1'b0, 16'h0002, 32'h0, 32'h0, 1'b0, 1'b1, 20);
      idle(2);

      chk("sb_empty", 21, 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
